// File: rtl/shift_sequencer.sv
// shift_sequencer
// Runs one shift-by-amount request as a series of single-bit steps on an
// external Shifter. Each step's result is fed back as the next operand. The
// final value comes back with a one-cycle o_done pulse.
// Build option SHIFT_SEQ_TIMEOUT_EN adds a per-step watchdog. If a step is
// still pending after TIMEOUT WAIT cycles, the remaining steps are abandoned
// and o_error is flagged.
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | ready; accepts a request
// ISSUE | one-cycle start pulse for the current step
// WAIT  | step in flight; waiting for the Shifter to finish
// DONE  | one-cycle o_done; o_result presents the final value
module shift_sequencer #(
  parameter int N       = 4,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_left,
  input  logic          i_req_rotate,
  input  logic [AW-1:0] i_req_amount,
  input  logic [N-1:0]  i_req_value,
  output logic          o_done,
  output logic [N-1:0]  o_result,
  output logic          o_error,
  output logic          o_shift_start,
  input  logic          i_shift_finished,
  output logic          o_shift_left,
  output logic          o_shift_rotate,
  output logic [N-1:0]  o_shift_value,
  input  logic [N-1:0]  i_shift_value
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_left;
  logic          r_rotate;
  logic [N-1:0]  r_work;
  logic [N-1:0]  r_result;
  logic [AW-1:0] r_count;
  logic          w_timeout;

`ifdef SHIFT_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_tmo_cnt;
  logic          r_error;

  // Watchdog: reload on every ISSUE, count down while the step is pending.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_tmo_cnt <= TW'(TIMEOUT - 1);
    end else if ((r_state == S_WAIT) && (r_tmo_cnt != '0)) begin
      r_tmo_cnt <= r_tmo_cnt - TW'(1);
    end
  end

  // Terminal count reached on the last allowed WAIT cycle with no finish seen.
  assign w_timeout = (r_state == S_WAIT) && !i_shift_finished && (r_tmo_cnt == '0);

  // Capture the error cause on the way into DONE so it lines up with o_done.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (w_state_nxt == S_DONE) begin
      r_error <= w_timeout;
    end
  end

  assign o_error = r_error && (r_state == S_DONE);
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign o_error          = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_nxt   = r_state;
    o_req_ready   = 1'b0;
    o_shift_start = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_state_nxt = (i_req_amount == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_shift_start = 1'b1;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (i_shift_finished) begin
          w_state_nxt = (r_count == AW'(1)) ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, working operand, step count and held result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_left   <= 1'b0;
      r_rotate <= 1'b0;
      r_work   <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_left   <= i_req_left;
            r_rotate <= i_req_rotate;
            r_work   <= i_req_value;
            r_count  <= i_req_amount;
          end
        end
        S_WAIT: begin
          if (i_shift_finished) begin
            r_work  <= i_shift_value;
            r_count <= r_count - AW'(1);
          end
        end
        S_DONE: begin
          r_result <= r_work;
        end
        default: begin
        end
      endcase
    end
  end

  // The working value is presented during DONE. The registered copy holds it
  // afterwards until the next o_done.
  assign o_result       = (r_state == S_DONE) ? r_work : r_result;
  assign o_shift_left   = r_left;
  assign o_shift_rotate = r_rotate;
  assign o_shift_value  = r_work;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// Drives shift_sequencer against a behavioural single-step Shifter model with
// a programmable latency. Final results are compared with a closed-form
// shift/rotate reference. Watchdog cases are compiled in only when
// SHIFT_SEQ_TIMEOUT_EN is defined.
module tb_shift_sequencer;

  localparam int N       = 4;
  localparam int AW      = 3;
  localparam int TIMEOUT = 16;

  logic          i_clock          = 1'b0;
  logic          i_reset          = 1'b1;
  logic          i_req_valid      = 1'b0;
  logic          o_req_ready;
  logic          i_req_left       = 1'b0;
  logic          i_req_rotate     = 1'b0;
  logic [AW-1:0] i_req_amount     = '0;
  logic [N-1:0]  i_req_value      = '0;
  logic          o_done;
  logic [N-1:0]  o_result;
  logic          o_error;
  logic          o_shift_start;
  logic          i_shift_finished = 1'b0;
  logic          o_shift_left;
  logic          o_shift_rotate;
  logic [N-1:0]  o_shift_value;
  logic [N-1:0]  i_shift_value    = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Shifter model controls, written only by the main stimulus process.
  int sh_lat        = 1;
  int sh_steps_left = 1000;

  // Shifter model state.
  bit           sh_busy = 1'b0;
  int           sh_cnt  = 0;
  logic [N-1:0] sh_op   = '0;
  bit           sh_l    = 1'b0;
  bit           sh_r    = 1'b0;

  shift_sequencer #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_left       (i_req_left),
    .i_req_rotate     (i_req_rotate),
    .i_req_amount     (i_req_amount),
    .i_req_value      (i_req_value),
    .o_done           (o_done),
    .o_result         (o_result),
    .o_error          (o_error),
    .o_shift_start    (o_shift_start),
    .i_shift_finished (i_shift_finished),
    .o_shift_left     (o_shift_left),
    .o_shift_rotate   (o_shift_rotate),
    .o_shift_value    (o_shift_value),
    .i_shift_value    (i_shift_value)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Closed-form result of shifting/rotating v by k positions.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input bit l,
                                             input bit r, input int k);
    int x;
    int full;
    int m;
    x    = int'(v);
    full = 1 << N;
    if (!r) begin
      if (k >= N) return '0;
      if (l) return N'((x << k) % full);
      return N'(x >> k);
    end
    m = k % N;
    if (l) return N'(((x << m) | (x >> (N - m))) % full);
    return N'(((x >> m) | (x << (N - m))) % full);
  endfunction

  // One single-bit step of the Shifter datapath.
  function automatic logic [N-1:0] one_step(input logic [N-1:0] v, input bit l, input bit r);
    if (l) return {v[N-2:0], r ? v[N-1] : 1'b0};
    return {r ? v[0] : 1'b0, v[N-1:1]};
  endfunction

  // Shifter model: finishes sh_lat cycles after start. When no step is
  // pending it throws in stray finished pulses that the sequencer must ignore.
  initial begin
    forever begin
      @(negedge i_clock);
      i_shift_finished = 1'b0;
      if (o_req_ready === 1'b1) sh_busy = 1'b0;
      if (sh_busy) begin
        if (sh_cnt > 0) begin
          chk("stable_left",   int'(o_shift_left),   int'(sh_l));
          chk("stable_rotate", int'(o_shift_rotate), int'(sh_r));
          chk("stable_value",  int'(o_shift_value),  int'(sh_op));
          sh_cnt--;
          if ((sh_cnt == 0) && (sh_steps_left > 0)) begin
            i_shift_finished = 1'b1;
            i_shift_value    = one_step(sh_op, sh_l, sh_r);
            sh_busy          = 1'b0;
            sh_steps_left--;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        i_shift_finished = 1'b1;
        i_shift_value    = N'($urandom);
      end
      if (o_shift_start === 1'b1) begin
        sh_busy = 1'b1;
        sh_cnt  = sh_lat;
        sh_op   = o_shift_value;
        sh_l    = o_shift_left;
        sh_r    = o_shift_rotate;
      end
    end
  end

  // Must be entered at a negedge with the DUT in IDLE. Returns at the negedge
  // of the IDLE cycle that follows DONE, so back-to-back calls reuse that cycle.
  task automatic run_req(input string tag, input bit l, input bit r, input int k,
                         input logic [N-1:0] v, input int lat, input logic [N-1:0] exp_res,
                         input bit exp_err, input int exp_lat, input int exp_starts);
    int cyc;
    int starts;
    int busy_ready;
    bit got;
    chk({tag, "_ready"}, int'(o_req_ready), 1);
    sh_lat       = lat;
    i_req_valid  = 1'b1;
    i_req_left   = l;
    i_req_rotate = r;
    i_req_amount = AW'(k);
    i_req_value  = v;
    @(posedge i_clock);
    #1;
    i_req_valid  = 1'b0;
    i_req_left   = 1'($urandom);
    i_req_rotate = 1'($urandom);
    i_req_amount = AW'($urandom);
    i_req_value  = N'($urandom);
    cyc        = 0;
    starts     = 0;
    busy_ready = 0;
    got        = 1'b0;
    while (!got && (cyc < 300)) begin
      @(negedge i_clock);
      cyc++;
      if (o_shift_start) starts++;
      if (o_done) begin
        got         = 1'b1;
        i_req_valid = 1'b0;
      end else begin
        if (o_req_ready) busy_ready++;
        i_req_valid = ($urandom_range(0, 3) == 0);
      end
    end
    i_req_valid = 1'b0;
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_result"}, int'(o_result), int'(exp_res));
    chk({tag, "_error"}, int'(o_error), int'(exp_err));
    chk({tag, "_starts"}, starts, exp_starts);
    chk({tag, "_ready_busy"}, busy_ready, 0);
    @(negedge i_clock);
    chk({tag, "_done_pulse"}, int'(o_done), 0);
    chk({tag, "_held"}, int'(o_result), int'(exp_res));
  endtask

  task automatic run_norm(input string tag, input bit l, input bit r, input int k,
                          input logic [N-1:0] v, input int lat);
    run_req(tag, l, r, k, v, lat, ref_shift(v, l, r, k), 1'b0, k * (lat + 1) + 1, k);
  endtask

  initial begin
    int starts;
    int cyc;
    int done_seen;
    bit rl;
    bit rr;
    int rk;
    logic [N-1:0] rv;

    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_ready",  int'(o_req_ready),   1);
    chk("rst_done",   int'(o_done),        0);
    chk("rst_error",  int'(o_error),       0);
    chk("rst_start",  int'(o_shift_start), 0);
    chk("rst_left",   int'(o_shift_left),  0);
    chk("rst_rotate", int'(o_shift_rotate), 0);
    chk("rst_result", int'(o_result),      0);
    chk("rst_value",  int'(o_shift_value), 0);

    run_norm("t1_left_log1",  1'b1, 1'b0, 1, 4'b1001, 1);
    run_norm("t2_right_rot3", 1'b0, 1'b1, 3, 4'b1001, 2);
    chk("t2_literal", int'(o_result), int'(4'b0011));
    run_norm("t3_amount0",    1'b0, 1'b0, 0, 4'b0110, 3);
    chk("t3_literal", int'(o_result), int'(4'b0110));
    run_norm("t4_left_log7",  1'b1, 1'b0, 7, 4'b1111, 2);
    chk("t4_literal", int'(o_result), 0);
    run_norm("rot_by_n",      1'b1, 1'b1, 4, 4'b1011, 1);
    run_norm("right_log_big", 1'b0, 1'b0, 5, 4'b1111, 4);

    // Reset during the second WAIT of an amount=3 request.
    sh_lat       = 3;
    i_req_valid  = 1'b1;
    i_req_left   = 1'b1;
    i_req_rotate = 1'b1;
    i_req_amount = AW'(3);
    i_req_value  = 4'b1001;
    @(posedge i_clock);
    #1;
    i_req_valid = 1'b0;
    starts = 0;
    cyc    = 0;
    while ((starts < 2) && (cyc < 100)) begin
      @(negedge i_clock);
      cyc++;
      if (o_shift_start) starts++;
    end
    chk("t5_two_starts", starts, 2);
    @(negedge i_clock);
    chk("t5_in_wait", int'(o_req_ready | o_shift_start | o_done), 0);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset   = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clock);
      if (o_done) done_seen++;
      if (i == 0) begin
        chk("t5_idle_ready", int'(o_req_ready),    1);
        chk("t5_result_clr", int'(o_result),       0);
        chk("t5_value_clr",  int'(o_shift_value),  0);
        chk("t5_left_clr",   int'(o_shift_left),   0);
        chk("t5_rotate_clr", int'(o_shift_rotate), 0);
      end
    end
    chk("t5_no_done", done_seen, 0);
    run_norm("t5_after_rst", 1'b0, 1'b1, 2, 4'b0110, 2);

`ifdef SHIFT_SEQ_TIMEOUT_EN
    // Shifter never finishes: o_result is the untouched operand.
    sh_steps_left = 0;
    run_req("t6_stall_first", 1'b1, 1'b0, 2, 4'b0101, 1, 4'b0101, 1'b1, TIMEOUT + 2, 1);
    // First step completes, second stalls: result is the value after step one.
    sh_steps_left = 1;
    run_req("t6_stall_second", 1'b1, 1'b0, 3, 4'b0101, 1, 4'b1010, 1'b1, 2 + TIMEOUT + 2, 2);
    sh_steps_left = 1000;
    run_norm("t6_recover", 1'b0, 1'b1, 3, 4'b1100, 3);
`endif

    for (int it = 0; it < 30; it++) begin
      rl = 1'($urandom);
      rr = 1'($urandom);
      rk = int'($urandom_range(0, 7));
      rv = N'($urandom);
      run_norm("rand", rl, rr, rk, rv, int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
